// File: rtl/hilo_pkg.sv
// Shared HILO definitions: operation codes, issue-controller FSM state
// encodings, common widths and the latched request payload.
// Used by hilo_issue_ctrl and by the HILO unit.
package hilo_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned ST_W   = 2;

  // Pipeline / HILO unit operation codes
  localparam logic [OP_W-1:0] OP_NONE  = 3'd0;
  localparam logic [OP_W-1:0] OP_MULT  = 3'd1;
  localparam logic [OP_W-1:0] OP_MULTU = 3'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 3'd3;
  localparam logic [OP_W-1:0] OP_DIVU  = 3'd4;
  localparam logic [OP_W-1:0] OP_MTHI  = 3'd5;
  localparam logic [OP_W-1:0] OP_MTLO  = 3'd6;
  localparam logic [OP_W-1:0] OP_MF    = 3'd7;

  // Issue-controller FSM states
  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_WAIT  = 2'd1;
  localparam logic [ST_W-1:0] ST_ISSUE = 2'd2;

  // Write request held while waiting for the issue slot
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } hilo_req_t;

endpackage : hilo_pkg

// File: rtl/hilo_issue_ctrl.sv
// hilo_issue_ctrl: sequences HI/LO writes from the pipeline into the HILO
// unit. Multiply/divide writes are held for MUL_LAT/DIV_LAT wait cycles and
// then issued for one cycle; MTHI/MTLO issue on the next cycle; MFHI/MFLO
// reads are answered one cycle after acceptance. Requests are only accepted
// in IDLE, so a read always follows the commit of any earlier write.
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-low reset
//   req_valid   request present          req_ready  accepted (IDLE only)
//   req_op      opcode 0..7              req_sel_hi MF read selects HI
//   req_a/b     rs/rt operands
//   hilo_op     write opcode to HILO unit (0 outside the issue cycle)
//   hilo_a/b    latched operands to HILO unit
//   hilo_hi/lo  current HI/LO values from the HILO unit
//   rd_valid    MF read result valid     rd_data    MF read result
//   div0_err    divide-by-zero trap pulse (only with HILO_DIV0_TRAP_EN)
//   busy        controller not IDLE; pipeline stall
//
// Build option: define HILO_DIV0_TRAP_EN to trap DIV/DIVU with req_b == 0
// instead of issuing it.
module hilo_issue_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic              req_sel_hi,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [OP_W-1:0]   hilo_op,
  output logic [DATA_W-1:0] hilo_a,
  output logic [DATA_W-1:0] hilo_b,
  input  logic [DATA_W-1:0] hilo_hi,
  input  logic [DATA_W-1:0] hilo_lo,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
`ifdef HILO_DIV0_TRAP_EN
  output logic              div0_err,
`endif
  output logic              busy
);

  // Counter preload: LAT-1 gives exactly LAT wait cycles; LAT=32 loads 31
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  logic [ST_W-1:0]   r_state,    w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,      w_cnt_nxt;
  hilo_req_t         r_req,      w_req_nxt;
  logic [OP_W-1:0]   r_hilo_op,  w_hilo_op_nxt;
  logic              r_rd_valid, w_rd_valid_nxt;
  logic [DATA_W-1:0] r_rd_data,  w_rd_data_nxt;
  logic              r_div0_err, w_div0_err_nxt;
  logic              w_accept;
  logic              w_div0_trap;

  assign w_accept = req_valid && (r_state == ST_IDLE);

`ifdef HILO_DIV0_TRAP_EN
  assign w_div0_trap = (req_b == '0);
`else
  assign w_div0_trap = 1'b0;
`endif

  // Next-state, counter, latch and output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_req_nxt      = r_req;
    w_hilo_op_nxt  = OP_NONE;
    w_rd_valid_nxt = 1'b0;
    w_rd_data_nxt  = r_rd_data;
    w_div0_err_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (req_op)
            OP_MULT, OP_MULTU: begin
              w_req_nxt   = '{op: req_op, a: req_a, b: req_b};
              w_cnt_nxt   = MUL_CNT;
              w_state_nxt = ST_WAIT;
            end
            OP_DIV, OP_DIVU: begin
              if (w_div0_trap) begin
                w_div0_err_nxt = 1'b1;
              end else begin
                w_req_nxt   = '{op: req_op, a: req_a, b: req_b};
                w_cnt_nxt   = DIV_CNT;
                w_state_nxt = ST_WAIT;
              end
            end
            OP_MTHI, OP_MTLO: begin
              w_req_nxt     = '{op: req_op, a: req_a, b: req_b};
              w_hilo_op_nxt = req_op;
              w_state_nxt   = ST_ISSUE;
            end
            OP_MF: begin
              w_rd_valid_nxt = 1'b1;
              w_rd_data_nxt  = req_sel_hi ? hilo_hi : hilo_lo;
            end
            default: ;
          endcase
        end
      end
      ST_WAIT: begin
        // hilo_op is registered, so it is loaded on the edge entering ISSUE
        if (r_cnt == '0) begin
          w_hilo_op_nxt = r_req.op;
          w_state_nxt   = ST_ISSUE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and data registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_req      <= '0;
      r_hilo_op  <= OP_NONE;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_div0_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_req      <= w_req_nxt;
      r_hilo_op  <= w_hilo_op_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_div0_err <= w_div0_err_nxt;
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign hilo_op   = r_hilo_op;
  assign hilo_a    = r_req.a;
  assign hilo_b    = r_req.b;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;

`ifdef HILO_DIV0_TRAP_EN
  assign div0_err  = r_div0_err;
`else
  logic w_unused;
  assign w_unused  = r_div0_err;
`endif

endmodule : hilo_issue_ctrl

// File: tb/tb_hilo_issue_ctrl.sv
// Testbench for hilo_issue_ctrl: scripted vector table, hand-written corner
// sequences (reset in WAIT, divide by zero, latency bounds on a second
// instance with MUL_LAT=32/DIV_LAT=1) and a randomized run against a
// cycle-count reference model. A small HILO unit model closes the loop.
module tb_hilo_issue_ctrl;
  import hilo_pkg::*;

  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned DIV_LAT = 8;
`ifdef HILO_DIV0_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_sel_hi;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        req_ready, busy, rd_valid;
  logic [2:0]  hilo_op;
  logic [31:0] hilo_a, hilo_b, rd_data;
  logic [31:0] env_hi = '0, env_lo = '0;
  logic        div0_err;

  // second instance for counter bounds
  logic        r2_valid, r2_sel;
  logic [2:0]  r2_op;
  logic [31:0] r2_a, r2_b;
  logic        ready2, busy2, rdv2, div0_2;
  logic [2:0]  hop2;
  logic [31:0] ha2, hb2, rdd2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hilo_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_sel_hi(req_sel_hi), .req_a(req_a), .req_b(req_b),
    .hilo_op(hilo_op), .hilo_a(hilo_a), .hilo_b(hilo_b),
    .hilo_hi(env_hi), .hilo_lo(env_lo), .rd_valid(rd_valid), .rd_data(rd_data),
`ifdef HILO_DIV0_TRAP_EN
    .div0_err(div0_err),
`endif
    .busy(busy)
  );

  hilo_issue_ctrl #(.MUL_LAT(32), .DIV_LAT(1)) dut2 (
    .clk(clk), .rst(rst), .req_valid(r2_valid), .req_ready(ready2),
    .req_op(r2_op), .req_sel_hi(r2_sel), .req_a(r2_a), .req_b(r2_b),
    .hilo_op(hop2), .hilo_a(ha2), .hilo_b(hb2),
    .hilo_hi(32'h0), .hilo_lo(32'h0), .rd_valid(rdv2), .rd_data(rdd2),
`ifdef HILO_DIV0_TRAP_EN
    .div0_err(div0_2),
`endif
    .busy(busy2)
  );

`ifndef HILO_DIV0_TRAP_EN
  assign div0_err = 1'b0;
  assign div0_2   = 1'b0;
`endif

  // Architectural HI/LO result of one write
  function automatic logic [63:0] hilo_apply(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
    logic signed [63:0] p;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      OP_MULT: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p;
      end
      OP_MULTU: return {32'h0, a} * {32'h0, b};
      OP_DIV: begin
        if (b == 32'h0) return {hi, lo};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      OP_DIVU: begin
        if (b == 32'h0) return {hi, lo};
        return {a % b, a / b};
      end
      OP_MTHI: return {a, lo};
      OP_MTLO: return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction

  // HILO unit: commits on the edge ending the issue cycle
  always @(posedge clk) begin
    if (hilo_op != OP_NONE) {env_hi, env_lo} <= hilo_apply(hilo_op, hilo_a, hilo_b, env_hi, env_lo);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic sel,
                       input logic [31:0] a, input logic [31:0] b);
    req_valid  = v;
    req_op     = op;
    req_sel_hi = sel;
    req_a      = a;
    req_b      = b;
  endtask

  task automatic drive2(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    r2_valid = v;
    r2_op    = op;
    r2_sel   = 1'b0;
    r2_a     = a;
    r2_b     = b;
  endtask

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic        sel;
    logic [31:0] a, b;
    logic        e_ready, e_busy;
    logic [2:0]  e_hop;
    logic        e_rdv;
    logic [31:0] e_rd;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [2:0] op, input logic sel,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic e_ready, input logic e_busy,
                              input logic [2:0] e_hop, input logic e_rdv,
                              input logic [31:0] e_rd);
    vec_t r;
    r.v = v; r.op = op; r.sel = sel; r.a = a; r.b = b;
    r.e_ready = e_ready; r.e_busy = e_busy; r.e_hop = e_hop;
    r.e_rdv = e_rdv; r.e_rd = e_rd;
    return r;
  endfunction

  // reference model state (cycle-indexed schedule)
  int          cyc, idle_from, issue_cyc, rd_cyc, div0_cyc;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b, m_hi, m_lo, rd_exp;

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        tbl [27];
    int          k, nz;
    logic [31:0] hi0, lo0;
    logic        rv, rs, rn, e_ready;
    logic [2:0]  ro, e_hop;
    logic [31:0] ra, rb;

    // ---------------- vector table -----------------
    tbl[0] = mk(1, OP_MULT, 0, 32'hFFFF_FFFE, 32'd5, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1, OP_MULT, 0, 0);
    tbl[5]  = mk(1, OP_MF, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[6]  = mk(1, OP_MF, 1, 0, 0, 1, 0, 0, 1, 32'hFFFF_FFF6);
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hFFFF_FFFF);
    tbl[8]  = mk(1, OP_MTHI, 0, 32'h1234_5678, 0, 1, 0, 0, 0, 0);
    tbl[9]  = mk(1, OP_MF, 1, 0, 0, 0, 1, OP_MTHI, 0, 0);
    tbl[10] = mk(1, OP_MF, 1, 0, 0, 1, 0, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h1234_5678);
    tbl[12] = mk(1, OP_DIVU, 0, 32'd100, 32'd7, 1, 0, 0, 0, 0);
    for (int i = 13; i <= 20; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 1, OP_DIVU, 0, 0);
    tbl[22] = mk(1, OP_MF, 1, 0, 0, 1, 0, 0, 0, 0);
    tbl[23] = mk(1, OP_MF, 0, 0, 0, 1, 0, 0, 1, 32'd2);
    tbl[24] = mk(1, OP_MF, 1, 0, 0, 1, 0, 0, 1, 32'd14);
    tbl[25] = mk(1, OP_NONE, 0, 0, 0, 1, 0, 0, 1, 32'd2);
    tbl[26] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // ---------------- reset -----------------
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive2(0, 0, 0, 0);
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hilo_op", 32'(hilo_op), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_hilo_a", hilo_a, 32'd0);
    chk("rst_hilo_b", hilo_b, 32'd0);
    chk("rst_div0_err", 32'(div0_err), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].sel, tbl[i].a, tbl[i].b);
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_hilo_op", i), 32'(hilo_op), 32'(tbl[i].e_hop));
      chk($sformatf("tbl%0d_rd_valid", i), 32'(rd_valid), 32'(tbl[i].e_rdv));
      if (tbl[i].e_rdv) chk($sformatf("tbl%0d_rd_data", i), rd_data, tbl[i].e_rd);
      tick();
    end

    // ---------------- reset during WAIT -----------------
    drive(1, OP_DIV, 0, 32'd50, 32'd3);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rstwait_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rstwait_busy", 32'(busy), 32'd0);
    chk("rstwait_ready", 32'(req_ready), 32'd1);
    chk("rstwait_rd_valid", 32'(rd_valid), 32'd0);
    chk("rstwait_rd_data", rd_data, 32'd0);
    nz = (hilo_op != OP_NONE) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (hilo_op != OP_NONE || busy) nz++;
    end
    chk("rstwait_no_issue", 32'(nz), 32'd0);

    // ---------------- divide by zero -----------------
    hi0 = env_hi;
    lo0 = env_lo;
    drive(1, OP_DIV, 0, 32'd9, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0);
    if (TRAP) begin
      chk("div0_err_pulse", 32'(div0_err), 32'd1);
      chk("div0_idle", 32'(busy), 32'd0);
      tick();
      chk("div0_err_drop", 32'(div0_err), 32'd0);
      nz = 0;
      for (int i = 0; i < 12; i++) begin
        if (hilo_op != OP_NONE) nz++;
        tick();
      end
      chk("div0_no_issue", 32'(nz), 32'd0);
    end else begin
      k = 1;
      while (hilo_op == OP_NONE && k < 20) begin
        tick();
        k++;
      end
      chk("div0_latency", 32'(k), 32'(DIV_LAT + 1));
      chk("div0_op", 32'(hilo_op), 32'(OP_DIV));
      tick();
    end
    drive(1, OP_MF, 1, 0, 0);
    tick();
    drive(1, OP_MF, 0, 0, 0);
    chk("div0_hi_kept", rd_data, hi0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("div0_lo_kept", rd_data, lo0);
    tick();

    // ---------------- counter bounds on dut2 -----------------
    drive2(1, OP_MULT, 32'd7, 32'd9);
    tick();
    drive2(0, 0, 0, 0);
    k = 1;
    while (hop2 == OP_NONE && k < 40) begin
      tick();
      k++;
    end
    chk("lat32_mul", 32'(k), 32'd33);
    chk("lat32_hilo_a", ha2, 32'd7);
    chk("lat32_hilo_b", hb2, 32'd9);
    tick();
    chk("lat32_back_idle", 32'(ready2), 32'd1);
    drive2(1, OP_DIVU, 32'd20, 32'd4);
    tick();
    drive2(0, 0, 0, 0);
    k = 1;
    while (hop2 == OP_NONE && k < 10) begin
      tick();
      k++;
    end
    chk("lat1_div", 32'(k), 32'd2);
    tick();

    // ---------------- randomized run vs reference model -----------------
    rst = 1'b0;
    tick();
    rst = 1'b1;
    cyc = 0; idle_from = 0; issue_cyc = -1; rd_cyc = -1; div0_cyc = -1;
    m_op = 0; m_a = 0; m_b = 0; rd_exp = 0;
    m_hi = env_hi;
    m_lo = env_lo;
    for (int n = 0; n < 3000; n++) begin
      rv = ($urandom_range(0, 3) != 0);
      ro = 3'($urandom_range(0, 7));
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      rn = ($urandom_range(0, 99) != 0);
      drive(rv, ro, rs, ra, rb);
      rst = rn;

      e_ready = (cyc >= idle_from);
      e_hop   = (cyc == issue_cyc) ? m_op : OP_NONE;
      chk("rnd_ready", 32'(req_ready), 32'(e_ready));
      chk("rnd_busy", 32'(busy), 32'(!e_ready));
      chk("rnd_hilo_op", 32'(hilo_op), 32'(e_hop));
      if (cyc == issue_cyc) begin
        chk("rnd_hilo_a", hilo_a, m_a);
        chk("rnd_hilo_b", hilo_b, m_b);
      end
      chk("rnd_rd_valid", 32'(rd_valid), 32'(cyc == rd_cyc));
      if (cyc == rd_cyc) chk("rnd_rd_data", rd_data, rd_exp);
      if (TRAP) chk("rnd_div0_err", 32'(div0_err), 32'(cyc == div0_cyc));

      // an issued write is committed by the HILO unit even if reset follows
      if (cyc == issue_cyc) {m_hi, m_lo} = hilo_apply(m_op, m_a, m_b, m_hi, m_lo);
      if (!rn) begin
        idle_from = cyc + 1;
        issue_cyc = -1;
        rd_cyc    = -1;
        div0_cyc  = -1;
      end else if (rv && e_ready) begin
        case (ro)
          OP_MULT, OP_MULTU: begin
            m_op = ro; m_a = ra; m_b = rb;
            issue_cyc = cyc + int'(MUL_LAT) + 1;
            idle_from = issue_cyc + 1;
          end
          OP_DIV, OP_DIVU: begin
            if (TRAP && rb == 32'd0) begin
              div0_cyc = cyc + 1;
            end else begin
              m_op = ro; m_a = ra; m_b = rb;
              issue_cyc = cyc + int'(DIV_LAT) + 1;
              idle_from = issue_cyc + 1;
            end
          end
          OP_MTHI, OP_MTLO: begin
            m_op = ro; m_a = ra; m_b = rb;
            issue_cyc = cyc + 1;
            idle_from = cyc + 2;
          end
          OP_MF: begin
            rd_cyc = cyc + 1;
            rd_exp = rs ? m_hi : m_lo;
          end
          default: ;
        endcase
      end
      tick();
      cyc++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_hilo_issue_ctrl
